// File: rtl/npc_pkg.sv
// npc_pkg: memory-op encodings, LSU state encoding and LSU defaults for the NPC core.
package npc_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    localparam int LSU_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP} lsu_state_t;

    function automatic logic lsu_bad_req(input logic rd, input logic wr, input logic [2:0] op,
                                         input logic [1:0] a);
        lsu_bad_req = (rd & wr)
                    | !(op inside {MEM_OP_B, MEM_OP_H, MEM_OP_W, MEM_OP_BU, MEM_OP_HU})
                    | (wr & op[2])
                    | ((op[1:0] == 2'b01) & a[0])
                    | ((op[1:0] == 2'b10) & (a != 2'b00));
    endfunction

    function automatic logic [3:0] lsu_wmask(input logic [1:0] sz, input logic [1:0] a);
        lsu_wmask = sz[1] ? 4'b1111 : (sz[0] ? 4'b0011 : 4'b0001) << a;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: shifts the addressed lane of a bus word down and sign/zero-extends it.
module lsu_load_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [31:0] sh;
    logic        sx;

    always_comb begin
        sh   = rdata >> {addr, 3'b000};
        sx   = ~op[2] & (op[0] ? sh[15] : sh[7]);
        data = op[1] ? sh : op[0] ? {{16{sx}}, sh[15:0]} : {{24{sx}}, sh[7:0]};
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit turning EXU requests into word-wide valid/ready bus transfers.
// Define LSU_TIMEOUT_EN to end a silent WAIT after TIMEOUT_CYCLES cycles with an error.
module lsu_ctrl import npc_pkg::*; #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd_en,
    input  logic              req_wr_en,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    lsu_state_t        state, state_nx;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q, ext;
    logic              accept, bad, timeout, done;

    assign accept = req_valid & req_ready & (req_rd_en | req_wr_en);
    assign bad    = lsu_bad_req(req_rd_en, req_wr_en, req_op, req_addr[1:0]);
    assign done   = (state == LSU_WAIT) & (mem_rsp_valid | timeout);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Held at zero outside WAIT, so every WAIT visit starts counting from zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (state == LSU_WAIT) ? cnt + 1'b1 : '0;

    assign timeout = (state == LSU_WAIT) & ~mem_rsp_valid & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    lsu_load_ext u_ext (
        .rdata(mem_rsp_rdata),
        .addr (lane_q),
        .op   (op_q),
        .data (ext)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= LSU_IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            LSU_IDLE: state_nx = accept ? (bad ? LSU_RESP : LSU_REQ) : LSU_IDLE;
            LSU_REQ:  state_nx = mem_req_ready ? LSU_WAIT : LSU_REQ;
            LSU_WAIT: state_nx = (mem_rsp_valid | timeout) ? LSU_RESP : LSU_WAIT;
            default:  state_nx = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = state == LSU_IDLE;
        mem_req_valid = state == LSU_REQ;
        rsp_valid     = state == LSU_RESP;
        rsp_err       = (state == LSU_RESP) & err_q;
        rsp_rdata     = (state == LSU_RESP) ? rdata_q : '0;
    end

    // Bus fields are captured at accept and stay frozen until the next accept
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_q          <= '0;
            lane_q        <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (accept) begin
            op_q          <= req_op;
            lane_q        <= req_addr[1:0];
            err_q         <= bad;
            rdata_q       <= '0;
            mem_req_we    <= req_wr_en;
            mem_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_req_wdata <= req_op[1] ? req_wdata :
                             req_op[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
            mem_req_wmask <= lsu_wmask(req_op[1:0], req_addr[1:0]);
        end else if (done) begin
            err_q   <= timeout;
            rdata_q <= (mem_req_we | timeout) ? '0 : ext;
        end

endmodule
